mdu_seq: RTL and testbench

- Multi-cycle multiply/divide unit for the pipelined MIPS core; sits beside the ALU in the EX stage.
- Driven by the decoder's start/mudiOp/hiWrite/loWrite outputs.
- Holds the architectural HI/LO registers, models configurable multiply and divide latency, and exposes busy to the hazard unit for stalling.
- Supports flush, so an in-flight operation can be cancelled on exception or interrupt.

---
 rtl/mdu_seq_if.sv | 26 ++
 rtl/mdu_seq.sv | 142 ++++++++++++++
 tb/tb_mdu_seq.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/mdu_seq_if.sv
// Decoder/hazard-unit side of the multiply/divide unit: request signals in,
// busy and the architectural HI/LO registers out.
interface mdu_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       mudiOp;
  logic             hiWrite;
  logic             loWrite;
  logic             flush;
  logic [WIDTH-1:0] rsData;
  logic [WIDTH-1:0] rtData;
  logic             busy;
  logic [WIDTH-1:0] hiOut;
  logic [WIDTH-1:0] loOut;

  modport master (
    output start, mudiOp, hiWrite, loWrite, flush, rsData, rtData,
    input  busy, hiOut, loOut
  );

  modport slave (
    input  start, mudiOp, hiWrite, loWrite, flush, rsData, rtData,
    output busy, hiOut, loOut
  );
endinterface

// File: rtl/mdu_seq.sv
// Multi-cycle MIPS multiply/divide unit: owns HI/LO, models a fixed mult/div
// latency with a down-counter, and supports mthi/mtlo and flush.
module mdu_seq #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  mdu_seq_if.slave   bus
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             busy;

  logic             accept, mtx, done, div0;
  logic [2*WIDTH-1:0] mul_r, div_r, res;

  // Full 2*WIDTH product; sign extension makes the low 2*WIDTH bits of an
  // unsigned multiply equal to the signed product when sgn is set.
  function automatic logic [2*WIDTH-1:0] mul_full(
    input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sgn);
    logic signed [2*WIDTH-1:0] ax, bx;
    ax = {{WIDTH{sgn & a[WIDTH-1]}}, a};
    bx = {{WIDTH{sgn & b[WIDTH-1]}}, b};
    return ax * bx;
  endfunction

  // Returns {remainder, quotient}. Done on magnitudes so that truncation toward
  // zero, remainder-follows-dividend and MIN/-1 wrap all fall out naturally.
  function automatic logic [2*WIDTH-1:0] div_full(
    input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sgn);
    logic             neg_a, neg_b;
    logic [WIDTH-1:0] ma, mb, q, r;
    neg_a = sgn & a[WIDTH-1];
    neg_b = sgn & b[WIDTH-1];
    ma    = neg_a ? -a : a;
    mb    = neg_b ? -b : b;
    if (mb == '0) mb = {{(WIDTH-1){1'b0}}, 1'b1};
    q = ma / mb;
    r = ma % mb;
    if (neg_a ^ neg_b) q = -q;
    if (neg_a)         r = -r;
    return {r, q};
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    accept = (state_q == IDLE) && bus.start && !bus.flush && !bus.mudiOp[2];
    mtx    = (state_q == IDLE) && !bus.start && !bus.flush;
    done   = (state_q == RUN) && !bus.flush && (cnt_q == CW'(1));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = RUN;
          cnt_d   = bus.mudiOp[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        end
      end
      RUN: begin
        if (bus.flush) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
  end

  assign bus.busy  = busy;
  assign bus.hiOut = hi_q;
  assign bus.loOut = lo_q;

  // Result datapath on the latched operands; op_q[1] selects divide,
  // op_q[0] selects unsigned.
  always_comb begin
    mul_r = mul_full(a_q, b_q, ~op_q[0]);
    div_r = div_full(a_q, b_q, ~op_q[0]);
    res   = op_q[1] ? div_r : mul_r;
    div0  = op_q[1] && (b_q == '0);
    hi_d  = hi_q;
    lo_d  = lo_q;
    if (done && !div0) begin
      hi_d = res[2*WIDTH-1:WIDTH];
      lo_d = res[WIDTH-1:0];
    end else if (mtx) begin
      if (bus.hiWrite) hi_d = bus.rsData;
      if (bus.loWrite) lo_d = bus.rsData;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (accept) begin
        op_q <= bus.mudiOp[1:0];
        a_q  <= bus.rsData;
        b_q  <= bus.rtData;
      end
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// Directed bench for mdu_seq: a 5/10-cycle instance for the main plan and a
// 1/1-cycle instance for the minimum-latency configuration.
module tb_mdu_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, hiWrite, loWrite, flush;
  logic [2:0]  mudiOp;
  logic [31:0] rsData, rtData;

  always #5 clk = ~clk;

  mdu_seq_if #(.WIDTH(32)) mif  ();
  mdu_seq_if #(.WIDTH(32)) mif1 ();

  assign mif.start   = start;   assign mif1.start   = start;
  assign mif.mudiOp  = mudiOp;  assign mif1.mudiOp  = mudiOp;
  assign mif.hiWrite = hiWrite; assign mif1.hiWrite = hiWrite;
  assign mif.loWrite = loWrite; assign mif1.loWrite = loWrite;
  assign mif.flush   = flush;   assign mif1.flush   = flush;
  assign mif.rsData  = rsData;  assign mif1.rsData  = rsData;
  assign mif.rtData  = rtData;  assign mif1.rtData  = rtData;

  mdu_seq #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) u_dut (
    .clk(clk), .reset(reset), .bus(mif));

  mdu_seq #(.WIDTH(32), .MULT_CYCLES(1), .DIV_CYCLES(1)) u_dut1 (
    .clk(clk), .reset(reset), .bus(mif1));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic busy_of(input int sel);
    return (sel != 0) ? mif1.busy : mif.busy;
  endfunction

  function automatic logic [31:0] hi_of(input int sel);
    return (sel != 0) ? mif1.hiOut : mif.hiOut;
  endfunction

  function automatic logic [31:0] lo_of(input int sel);
    return (sel != 0) ? mif1.loOut : mif.loOut;
  endfunction

  // inj: 0 none, 1 mthi 0xAB during busy cycle inj_cyc, 2 flush in that cycle
  task automatic run_op(input int sel, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic hw, input int inj,
                        input int inj_cyc, output int nb);
    start   = 1'b1;
    mudiOp  = op;
    rsData  = a;
    rtData  = b;
    hiWrite = hw;
    tick();
    start   = 1'b0;
    hiWrite = 1'b0;
    nb = 0;
    while (busy_of(sel) && nb < 200) begin
      nb++;
      if (inj == 1 && nb == inj_cyc) begin
        hiWrite = 1'b1;
        rsData  = 32'h0000_00AB;
      end
      if (inj == 2 && nb == inj_cyc) flush = 1'b1;
      tick();
      hiWrite = 1'b0;
      flush   = 1'b0;
    end
  endtask

  initial begin
    int nb;
    reset = 1'b1;
    start = 1'b0; hiWrite = 1'b0; loWrite = 1'b0; flush = 1'b0;
    mudiOp = 3'b000; rsData = '0; rtData = '0;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_hi",   mif.hiOut, 32'h0);
    chk("rst_lo",   mif.loOut, 32'h0);
    chk("rst_busy", {31'b0, mif.busy}, 32'h0);

    run_op(0, 3'b000, 32'hFFFF_FFFF, 32'h2, 1'b0, 0, 0, nb);
    chk("mult_busy", nb, 5);
    chk("mult_hi", hi_of(0), 32'hFFFF_FFFF);
    chk("mult_lo", lo_of(0), 32'hFFFF_FFFE);

    run_op(0, 3'b001, 32'hFFFF_FFFF, 32'h2, 1'b0, 0, 0, nb);
    chk("multu_busy", nb, 5);
    chk("multu_hi", hi_of(0), 32'h0000_0001);
    chk("multu_lo", lo_of(0), 32'hFFFF_FFFE);

    run_op(0, 3'b010, 32'hFFFF_FFF9, 32'h2, 1'b0, 0, 0, nb);
    chk("div_busy", nb, 10);
    chk("div_lo", lo_of(0), 32'hFFFF_FFFD);
    chk("div_hi", hi_of(0), 32'hFFFF_FFFF);

    run_op(0, 3'b011, 32'h7, 32'h2, 1'b0, 0, 0, nb);
    chk("divu_lo", lo_of(0), 32'h3);
    chk("divu_hi", hi_of(0), 32'h1);

    run_op(0, 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, 0, nb);
    chk("divmin_lo", lo_of(0), 32'h8000_0000);
    chk("divmin_hi", hi_of(0), 32'h0);

    hiWrite = 1'b1; rsData = 32'h11; tick();
    hiWrite = 1'b0; loWrite = 1'b1; rsData = 32'h22; tick();
    loWrite = 1'b0;
    chk("mthi", hi_of(0), 32'h11);
    chk("mtlo", lo_of(0), 32'h22);

    flush = 1'b1; hiWrite = 1'b1; rsData = 32'h55; tick();
    flush = 1'b0; hiWrite = 1'b0;
    chk("idle_flush_mthi", hi_of(0), 32'h11);

    start = 1'b1; mudiOp = 3'b100; tick();
    start = 1'b0;
    chk("invalid_op_busy", {31'b0, mif.busy}, 32'h0);

    run_op(0, 3'b011, 32'h5, 32'h0, 1'b0, 1, 2, nb);
    chk("div0_busy", nb, 10);
    chk("div0_run_mthi_hi", hi_of(0), 32'h11);
    chk("div0_lo", lo_of(0), 32'h22);

    run_op(0, 3'b011, 32'hAB, 32'h0, 1'b1, 0, 0, nb);
    chk("start_mthi_busy", nb, 10);
    chk("start_mthi_hi", hi_of(0), 32'h11);

    run_op(0, 3'b000, 32'h3, 32'h4, 1'b0, 2, 3, nb);
    chk("flush3_busy", nb, 3);
    chk("flush3_hi", hi_of(0), 32'h11);
    chk("flush3_lo", lo_of(0), 32'h22);

    run_op(0, 3'b000, 32'h3, 32'h4, 1'b0, 2, 5, nb);
    chk("flush_done_busy", nb, 5);
    chk("flush_done_hi", hi_of(0), 32'h11);
    chk("flush_done_lo", lo_of(0), 32'h22);

    run_op(0, 3'b000, 32'h3, 32'h4, 1'b0, 0, 0, nb);
    chk("mult34_hi", hi_of(0), 32'h0);
    chk("mult34_lo", lo_of(0), 32'hC);

    start = 1'b1; mudiOp = 3'b010; rsData = 32'd100; rtData = 32'd7; tick();
    start = 1'b0;
    tick(); tick();
    chk("middiv_busy", {31'b0, mif.busy}, 32'h1);
    #3 reset = 1'b1;
    #1;
    chk("async_rst_busy", {31'b0, mif.busy}, 32'h0);
    chk("async_rst_hi", mif.hiOut, 32'h0);
    chk("async_rst_lo", mif.loOut, 32'h0);
    tick();
    reset = 1'b0;
    tick();

    run_op(1, 3'b000, 32'hFFFF_FFFF, 32'h2, 1'b0, 0, 0, nb);
    chk("n1_mult_busy", nb, 1);
    chk("n1_mult_hi", hi_of(1), 32'hFFFF_FFFF);
    chk("n1_mult_lo", lo_of(1), 32'hFFFF_FFFE);
    tick(); tick(); tick(); tick(); tick();

    run_op(1, 3'b010, 32'hFFFF_FFF9, 32'h2, 1'b0, 0, 0, nb);
    chk("n1_div_busy", nb, 1);
    chk("n1_div_lo", lo_of(1), 32'hFFFF_FFFD);
    chk("n1_div_hi", hi_of(1), 32'hFFFF_FFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
